// File: rtl/r_l_bank_controller.sv
// ============================================================================
// Module   : r_l_bank_controller
// Purpose  : Read/load arbiter over a ring of buffer banks with burst-aligned
//            mode switching, per-bank full flags and load overrun detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module r_l_bank_controller #(
  parameter int NUM_BANKS  = 2,
  parameter int LOAD_BURST = 7,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int AW = $clog2(LOAD_BURST),
  localparam int FW = $clog2(NUM_BANKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_l_con,
  input  logic          fdata_strb,
  input  logic          load_strb,
  input  logic          rd_done,
  output logic          r_l_state,
  output logic          load_we,
  output logic [BW-1:0] load_bank,
  output logic [AW-1:0] load_addr,
  output logic          rd_valid,
  output logic [BW-1:0] rd_bank,
  output logic [FW-1:0] full_cnt,
  output logic          overrun,
  output logic          overrun_sticky
);

  localparam logic [AW-1:0] LAST_IDX = AW'(LOAD_BURST - 1);

  logic                 mode_q,         mode_d;
  logic                 burst_mode_q,   burst_mode_d;
  logic                 accept_q,       accept_d;
  logic [AW-1:0]        burst_cnt_q,    burst_cnt_d;
  logic [NUM_BANKS-1:0] full_q,         full_d;
  logic [BW-1:0]        load_bank_q,    load_bank_d;
  logic [BW-1:0]        rd_bank_q,      rd_bank_d;
  logic                 load_we_q,      load_we_d;
  logic [AW-1:0]        load_addr_q,    load_addr_d;
  logic                 rd_valid_q,     rd_valid_d;
  logic [FW-1:0]        full_cnt_q,     full_cnt_d;
  logic                 overrun_q,      overrun_d;
  logic                 sticky_q,       sticky_d;

  logic start;
  logic last;
  logic cur_mode;
  logic cur_accept;
  logic do_write;
  logic do_fill;
  logic do_clear;

  always_comb begin
    start      = load_strb && (burst_cnt_q == '0);
    last       = load_strb && (burst_cnt_q == LAST_IDX);
    // The start pulse acts on the freshly latched burst attributes, so use
    // the values being captured rather than the stale registers.
    cur_mode   = start ? mode_q : burst_mode_q;
    cur_accept = start ? !full_q[load_bank_q] : accept_q;
    do_write   = load_strb && cur_mode && cur_accept;
    do_fill    = last && cur_mode && cur_accept;
    do_clear   = rd_done && rd_valid_q;
  end

  always_comb begin
    mode_d       = fdata_strb ? r_l_con : mode_q;
    burst_mode_d = start ? mode_q : burst_mode_q;
    accept_d     = start ? !full_q[load_bank_q] : accept_q;

    burst_cnt_d = burst_cnt_q;
    if (load_strb) begin
      burst_cnt_d = last ? '0 : burst_cnt_q + AW'(1);
    end

    load_we_d   = do_write;
    load_addr_d = do_write ? burst_cnt_q : load_addr_q;
    overrun_d   = start && mode_q && full_q[load_bank_q];
    sticky_d    = sticky_q || overrun_d;

    // Clear and fill never target the same bank: a filling bank was empty
    // at burst start, so rd_valid could not have been set for it.
    full_d = full_q;
    if (do_clear) full_d[rd_bank_q] = 1'b0;
    if (do_fill)  full_d[load_bank_q] = 1'b1;

    load_bank_d = do_fill  ? load_bank_q + BW'(1) : load_bank_q;
    rd_bank_d   = do_clear ? rd_bank_q + BW'(1)   : rd_bank_q;
    rd_valid_d  = full_d[rd_bank_d];

    full_cnt_d = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      full_cnt_d = full_cnt_d + FW'(full_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= 1'b0;
      burst_mode_q <= 1'b0;
      accept_q     <= 1'b0;
      burst_cnt_q  <= '0;
      full_q       <= '0;
      load_bank_q  <= '0;
      rd_bank_q    <= '0;
      load_we_q    <= 1'b0;
      load_addr_q  <= '0;
      rd_valid_q   <= 1'b0;
      full_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      burst_mode_q <= burst_mode_d;
      accept_q     <= accept_d;
      burst_cnt_q  <= burst_cnt_d;
      full_q       <= full_d;
      load_bank_q  <= load_bank_d;
      rd_bank_q    <= rd_bank_d;
      load_we_q    <= load_we_d;
      load_addr_q  <= load_addr_d;
      rd_valid_q   <= rd_valid_d;
      full_cnt_q   <= full_cnt_d;
      overrun_q    <= overrun_d;
      sticky_q     <= sticky_d;
    end
  end

  assign r_l_state      = burst_mode_q;
  assign load_we        = load_we_q;
  assign load_bank      = load_bank_q;
  assign load_addr      = load_addr_q;
  assign rd_valid       = rd_valid_q;
  assign rd_bank        = rd_bank_q;
  assign full_cnt       = full_cnt_q;
  assign overrun        = overrun_q;
  assign overrun_sticky = sticky_q;

endmodule

`default_nettype wire
